mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one signed shift-add multiplier (St/Done handshake, W-bit operands, 2W-bit Product)
//  between NREQ requesters. Round-robin arbitration, operand latching, St/Done sequencing,
//  result return and a Done-timeout watchdog. Sits between client blocks and the multiplier.
// PARAMETERS
//  NREQ        4    number of requesters (2..8)
//  W           16   operand width; product is 2W
//  TIMEOUT_CYC 40   max cycles from St rise to Done before abort (multiplier nominal ~W+4)
// PORTS
//  clk          in   1        system clock; one clock domain
//  rst          in   1        synchronous reset, active-high
//  req          in   NREQ     req[i] high = requester i wants a product; held until its rsp_valid
//  mplier_in    in   NREQ*W   packed multipliers, slice i = [i*W +: W], signed
//  mcand_in     in   NREQ*W   packed multiplicands, same packing, signed
//  gnt          out  NREQ     one-hot; requester i owns the multiplier (LOAD..DRAIN)
//  rsp_valid    out  NREQ     one-cycle pulse to owner: product_out/rsp_err valid this cycle
//  product_out  out  2W       result of owner's operation, held until next rsp_valid
//  rsp_err      out  1        with rsp_valid: 1 = timed out, product_out forced 0
//  busy         out  1        high in every state except IDLE
//  mul_st       out  1        St to multiplier
//  mul_mplier   out  W        Mplier to multiplier (registered)
//  mul_mcand    out  W        Mcand to multiplier (registered)
//  mul_done     in   1        Done from multiplier
//  mul_product  in   2W       Product from multiplier
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE, gnt=0, rsp_valid=0, rsp_err=0, product_out=0, busy=0,
//   mul_st=0, mul_mplier=0, mul_mcand=0, rr pointer=NREQ-1 (so req[0] wins first), timer=0.
//   Reset mid-operation drops St; multiplier returns to its idle on St low by itself.
//  States: IDLE -> LOAD -> WAIT -> RESP -> DRAIN -> IDLE; WAIT -> ABORT -> DRAIN on timeout.
//  IDLE: if req!=0, pick first set bit searching from ptr+1 upward, wrapping; latch that
//   slice of mplier_in/mcand_in into mul_mplier/mul_mcand, set gnt one-hot, ptr<=winner -> LOAD.
//   req==0: stay, outputs quiet. Arbitration happens only in IDLE.
//  LOAD (1 cycle): mul_st=1, timer cleared -> WAIT.
//  WAIT: mul_st held 1 (multiplier keeps Done high only while St high). timer++ each cycle.
//   mul_done=1: product_out<=mul_product -> RESP. Else timer==TIMEOUT_CYC-1 -> ABORT.
//   Done and timeout same cycle: Done wins (normal result).
//  RESP (1 cycle): rsp_valid[owner]=1, rsp_err=0, mul_st=0 -> DRAIN.
//  ABORT (1 cycle): product_out=0, rsp_valid[owner]=1, rsp_err=1, mul_st=0 -> DRAIN.
//  DRAIN: mul_st=0, gnt still set; wait mul_done==0 then gnt=0 -> IDLE (min 1 cycle).
//  Latency: req seen in IDLE at cycle t -> mul_st high t+2 -> rsp_valid one cycle after Done seen.
//  Requester may drop req the cycle after rsp_valid; req still high in IDLE = new request,
//   subject to round-robin (ptr already advanced, so others waiting win first).
//  req[owner] dropped mid-operation: ignored; operation completes, rsp_valid still pulses.
//  Operand changes after grant ignored (latched). rsp_err cleared to 0 on next rsp_valid.
//  Product is 2W-bit two's complement, passed through unmodified; no arithmetic here.
// STRUCTURE
//  Package mult_arb_pkg: state enum (IDLE,LOAD,WAIT,RESP,ABORT,DRAIN, 3-bit), default W,
//   product width localparam PW=2*W, timer width $clog2(TIMEOUT_CYC+1).
//  Sub-module rr_arbiter (NREQ): inputs req, ptr; output one-hot grant + index; combinational.
//  Top: FSM, operand/result registers, timer; multiplier instantiated outside this block.
// TESTING (W=16, NREQ=4, behavioural multiplier model with Done after 20 cycles)
//  1 req[0], mplier=-5, mcand=3 -> single rsp_valid[0], product_out=32'hFFFF_FFF1, rsp_err=0.
//  2 req=4'b1111 held, distinct operands -> service order 0,1,2,3,0; each exactly one pulse.
//  3 req[2] after ptr=2, req[3] pending -> req[3] served before req[2] re-serviced.
//  4 model never raises Done -> at TIMEOUT_CYC after St rise: rsp_valid+rsp_err, product 0, IDLE.
//  5 rst pulsed during WAIT -> next cycle all outputs at reset values, mul_st=0; new req works.
//  6 -32768 x -32768 -> product_out=32'h4000_0000; Done+timeout same cycle -> rsp_err=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing arbiter.
package mult_arb_pkg;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_W       = 16;
    localparam int unsigned DEF_PW      = 2 * DEF_W;
    localparam int unsigned DEF_TIMEOUT = 40;
    localparam int unsigned DEF_TW      = $clog2(DEF_TIMEOUT + 1);

    // Operation sequencing states; ABORT replaces RESP when Done never arrives.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    // Timer width able to hold values 0..timeout.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above the last winner, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] index,
    output logic                    valid
);

    localparam int unsigned IW = $clog2(NREQ);

    // Scan ptr+1 .. ptr+NREQ (mod NREQ); the first hit wins.
    always_comb begin
        int unsigned pos;
        grant = '0;
        index = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                index      = IW'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one St/Done shift-add multiplier among NREQ requesters with a Done watchdog.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ        = DEF_NREQ,
    parameter int unsigned W           = DEF_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] mplier_in,
    input  logic [NREQ*W-1:0] mcand_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    product_out,
    output logic              rsp_err,
    output logic              busy,
    output logic              mul_st,
    output logic [W-1:0]      mul_mplier,
    output logic [W-1:0]      mul_mcand,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_product
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = timer_width(TIMEOUT_CYC);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] win_grant;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [W-1:0]    mplier_arr [NREQ];
    logic [W-1:0]    mcand_arr  [NREQ];

    // Unpack the per-requester operand slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign mplier_arr[g] = mplier_in[g*W +: W];
        assign mcand_arr[g]  = mcand_in[g*W +: W];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (win_grant),
        .index (win_idx),
        .valid (win_valid)
    );

    // Sequencer: grant, St/Done handshake, response pulse, watchdog, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            product_out <= '0;
            busy        <= 1'b0;
            mul_st      <= 1'b0;
            mul_mplier  <= '0;
            mul_mcand   <= '0;
            ptr         <= IW'(NREQ - 1);
            timer       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        mul_mplier <= mplier_arr[win_idx];
                        mul_mcand  <= mcand_arr[win_idx];
                        gnt        <= win_grant;
                        ptr        <= win_idx;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mul_st <= 1'b1;
                    timer  <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer + TW'(1);
                    // Done takes priority over a timeout in the same cycle.
                    if (mul_done) begin
                        product_out <= mul_product;
                        rsp_valid   <= gnt;
                        rsp_err     <= 1'b0;
                        mul_st      <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                        product_out <= PW'(0);
                        rsp_valid   <= gnt;
                        rsp_err     <= 1'b1;
                        mul_st      <= 1'b0;
                        state       <= ST_ABORT;
                    end
                end
                ST_RESP, ST_ABORT: begin
                    rsp_valid <= '0;
                    state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Hold ownership until the multiplier has released Done.
                    if (!mul_done) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    mul_st    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized self-checking bench for mult_share_arbiter with a behavioural multiplier.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 40;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*W-1:0]   mplier_in = '0;
    logic [NREQ*W-1:0]   mcand_in = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_valid;
    logic [2*W-1:0]      product_out;
    logic                rsp_err;
    logic                busy;
    logic                mul_st;
    logic [W-1:0]        mul_mplier;
    logic [W-1:0]        mul_mcand;
    logic                mul_done;
    logic [2*W-1:0]      mul_product;

    int total = 0;
    int bad   = 0;

    // Multiplier model: Done rises once St has been high for `delay` cycles.
    int delay      = 20;
    bit never_done = 1'b0;
    int st_cnt     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mul_st) st_cnt <= 0;
        else         st_cnt <= st_cnt + 1;
    end

    assign mul_done    = mul_st && !never_done && (st_cnt >= delay);
    assign mul_product = {{16{mul_mplier[15]}}, mul_mplier} * {{16{mul_mcand[15]}}, mul_mcand};

    mult_share_arbiter #(
        .NREQ        (NREQ),
        .W           (W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mplier_in   (mplier_in),
        .mcand_in    (mcand_in),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .product_out (product_out),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mul_st      (mul_st),
        .mul_mplier  (mul_mplier),
        .mul_mcand   (mul_mcand),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    // Reference: last-served requester, per the round-robin rule.
    int mptr = NREQ - 1;

    function automatic int pick(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int x;
        int y;
        x = int'($signed(a));
        y = int'($signed(b));
        return 32'(x * y);
    endfunction

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        mplier_in[i*W +: W] = a;
        mcand_in[i*W +: W]  = b;
    endtask

    task automatic wait_rsp(input int maxc, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != '0) got = 1'b1;
        end
    endtask

    task automatic wait_st(input int maxc, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (mul_st) got = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL idle_wait: busy=%b still set after %0d cycles, required 0", busy, c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mptr = NREQ - 1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({gnt, rsp_valid, product_out, rsp_err, busy, mul_st, mul_mplier, mul_mcand} !== '0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b rsp_valid=%b prod=%h err=%b busy=%b st=%b mp=%h mc=%h, required all 0",
                     gnt, rsp_valid, product_out, rsp_err, busy, mul_st, mul_mplier, mul_mcand);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single request, latency, operand latching and single-pulse response.
    task automatic test_single();
        bit got;
        int cyc;
        set_ops(0, 16'hFFFB, 16'd3);
        req = 4'b0001;
        wait_st(10, got, cyc);
        total++;
        if (!got || cyc != 2) begin
            bad++;
            $display("FAIL single_st_latency: got=%0d cycles=%0d, required 2", got, cyc);
        end
        set_ops(0, 16'd7, 16'd9);
        wait_rsp(100, got, cyc);
        total++;
        if (!got || cyc != delay + 1) begin
            bad++;
            $display("FAIL single_rsp_latency: got=%0d cycles=%0d, required %0d", got, cyc, delay + 1);
        end
        total++;
        if (rsp_valid !== 4'b0001 || gnt !== 4'b0001 || product_out !== 32'hFFFF_FFF1 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL single_result: rsp_valid=%b gnt=%b prod=%h err=%b, required 0001 0001 fffffff1 0",
                     rsp_valid, gnt, product_out, rsp_err);
        end
        req = '0;
        mptr = 0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0000 || product_out !== 32'hFFFF_FFF1) begin
            bad++;
            $display("FAIL single_pulse: rsp_valid=%b prod=%h, required 0000 fffffff1", rsp_valid, product_out);
        end
        wait_idle();
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL single_gnt_release: gnt=%b, required 0000", gnt);
        end
    endtask

    // All four held: order from reset must be 0,1,2,3,0.
    task automatic test_rr_all();
        bit got;
        int cyc;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [31:0] exp_p [NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            set_ops(i, a, b);
            exp_p[i] = ref_mul(a, b);
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int w;
            w = pick(req);
            wait_rsp(100, got, cyc);
            total++;
            if (!got || w != exp_seq[n] || rsp_valid !== 4'(1 << w) || product_out !== exp_p[w]) begin
                bad++;
                $display("FAIL rr_all_%0d: got=%0d rsp_valid=%b prod=%h, required %b %h",
                         n, got, rsp_valid, product_out, 4'(1 << exp_seq[n]), exp_p[exp_seq[n]]);
            end
            mptr = w;
            if (n == 4) req = '0;
            @(negedge clk);
            total++;
            if (rsp_valid !== 4'b0000) begin
                bad++;
                $display("FAIL rr_all_pulse_%0d: rsp_valid=%b, required 0000", n, rsp_valid);
            end
        end
        wait_idle();
    endtask

    // Requester 2 re-requests while 3 waits: 3 must be served first.
    task automatic test_rr_fair();
        bit got;
        int cyc;
        set_ops(2, 16'd100, 16'hFFFE);
        set_ops(3, 16'd1234, 16'd11);
        req = 4'b0100;
        wait_rsp(100, got, cyc);
        total++;
        if (!got || rsp_valid !== 4'b0100 || product_out !== ref_mul(16'd100, 16'hFFFE)) begin
            bad++;
            $display("FAIL fair_first: rsp_valid=%b prod=%h, required 0100 %h", rsp_valid, product_out, ref_mul(16'd100, 16'hFFFE));
        end
        mptr = 2;
        req = 4'b1100;
        wait_rsp(100, got, cyc);
        total++;
        if (!got || rsp_valid !== 4'(1 << pick(4'b1100)) || product_out !== ref_mul(16'd1234, 16'd11)) begin
            bad++;
            $display("FAIL fair_order: rsp_valid=%b prod=%h, required %b %h",
                     rsp_valid, product_out, 4'(1 << pick(4'b1100)), ref_mul(16'd1234, 16'd11));
        end
        mptr = 3;
        req = 4'b0100;
        wait_rsp(100, got, cyc);
        total++;
        if (!got || rsp_valid !== 4'b0100) begin
            bad++;
            $display("FAIL fair_second: rsp_valid=%b, required 0100", rsp_valid);
        end
        mptr = 2;
        req = '0;
        wait_idle();
    endtask

    // Done never arrives: abort exactly TMO cycles after St rise.
    task automatic test_timeout();
        bit got;
        int cyc;
        never_done = 1'b1;
        set_ops(1, 16'd5, 16'd5);
        req = 4'b0010;
        wait_st(10, got, cyc);
        wait_rsp(100, got, cyc);
        total++;
        if (!got || cyc != TMO) begin
            bad++;
            $display("FAIL timeout_latency: got=%0d cycles=%0d, required %0d", got, cyc, TMO);
        end
        total++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || product_out !== 32'h0) begin
            bad++;
            $display("FAIL timeout_result: rsp_valid=%b err=%b prod=%h, required 0010 1 00000000",
                     rsp_valid, rsp_err, product_out);
        end
        req = '0;
        mptr = 1;
        @(negedge clk);
        total++;
        if (mul_st !== 1'b0) begin
            bad++;
            $display("FAIL timeout_st_drop: mul_st=%b, required 0", mul_st);
        end
        never_done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL timeout_idle: busy=%b gnt=%b, required 0 0000", busy, gnt);
        end
    endtask

    // Reset during WAIT returns everything to reset values; pointer restarts.
    task automatic test_reset_mid();
        bit got;
        int cyc;
        set_ops(0, 16'd300, 16'd300);
        set_ops(1, 16'd2, 16'd2);
        req = 4'b0010;
        wait_st(10, got, cyc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({gnt, rsp_valid, product_out, rsp_err, busy, mul_st, mul_mplier, mul_mcand} !== '0) begin
            bad++;
            $display("FAIL reset_mid: gnt=%b rsp_valid=%b prod=%h err=%b busy=%b st=%b mp=%h mc=%h, required all 0",
                     gnt, rsp_valid, product_out, rsp_err, busy, mul_st, mul_mplier, mul_mcand);
        end
        rst = 1'b0;
        mptr = NREQ - 1;
        req = 4'b0011;
        wait_rsp(100, got, cyc);
        total++;
        if (!got || rsp_valid !== 4'(1 << pick(4'b0011)) || product_out !== ref_mul(16'd300, 16'd300) || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: rsp_valid=%b prod=%h err=%b, required 0001 %h 0",
                     rsp_valid, product_out, rsp_err, ref_mul(16'd300, 16'd300));
        end
        mptr = 0;
        req = '0;
        wait_idle();
    endtask

    // Extreme operands with Done on the last legal cycle, then one cycle late.
    task automatic test_boundary();
        bit got;
        int cyc;
        delay = TMO - 1;
        set_ops(1, 16'h8000, 16'h8000);
        req = 4'b0010;
        wait_st(10, got, cyc);
        wait_rsp(100, got, cyc);
        total++;
        if (!got || rsp_valid !== 4'b0010 || product_out !== 32'h4000_0000 || rsp_err !== 1'b0 || cyc != TMO) begin
            bad++;
            $display("FAIL boundary_done_at_limit: rsp_valid=%b prod=%h err=%b cycles=%0d, required 0010 40000000 0 %0d",
                     rsp_valid, product_out, rsp_err, cyc, TMO);
        end
        mptr = 1;
        req = '0;
        wait_idle();
        delay = TMO;
        set_ops(2, 16'h7FFF, 16'h8000);
        req = 4'b0100;
        wait_rsp(150, got, cyc);
        total++;
        if (!got || rsp_valid !== 4'b0100 || product_out !== 32'h0 || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL boundary_done_late: rsp_valid=%b prod=%h err=%b, required 0100 00000000 1",
                     rsp_valid, product_out, rsp_err);
        end
        mptr = 2;
        req = '0;
        wait_idle();
        delay = 20;
    endtask

    // Random request masks, operands and multiplier delays against the model.
    task automatic test_random();
        bit got;
        int cyc;
        logic [31:0] exp_p [NREQ];
        for (int it = 0; it < 12; it++) begin
            logic [NREQ-1:0] mask;
            mask = 4'($urandom_range(1, 15));
            delay = $urandom_range(1, 30);
            for (int i = 0; i < NREQ; i++) begin
                logic [15:0] a;
                logic [15:0] b;
                a = 16'($urandom);
                b = 16'($urandom);
                set_ops(i, a, b);
                exp_p[i] = ref_mul(a, b);
            end
            req = mask;
            while (mask != '0) begin
                int w;
                w = pick(mask);
                wait_rsp(150, got, cyc);
                total++;
                if (!got || rsp_valid !== 4'(1 << w) || product_out !== exp_p[w] || rsp_err !== 1'b0) begin
                    bad++;
                    $display("FAIL random_%0d: got=%0d rsp_valid=%b prod=%h err=%b, required %b %h 0",
                             it, got, rsp_valid, product_out, rsp_err, 4'(1 << w), exp_p[w]);
                end
                mptr = w;
                mask[w] = 1'b0;
                req = mask;
                if (!got) mask = '0;
            end
            wait_idle();
        end
        delay = 20;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_all();
        test_rr_fair();
        test_timeout();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
